sme_ks_arbiter: RTL and testbench

- Shares one masked Kogge-Stone add/sub unit (sme_ks_adder) between two requesters, port A and port B.
- Typical pairing: port A is the ALU add/sub path; port B is masked address or counter generation.
- Sequencing per operation: arbitrates, registers the winning operand shares, drives ks_en for the full adder sequence, captures the result shares on ks_rdy, then returns them over a valid/ready response to the granted requester.

---
 rtl/sme_ks_arbiter.sv | 158 +++++++++++++++
 tb/tb_sme_ks_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_ks_arbiter.sv
`timescale 1ns/1ps
// Two-port round-robin arbiter that time-shares one masked Kogge-Stone add/sub unit.
// Optional SME_KS_ARB_SCRUB_EN: zero the operand and result share registers once they are consumed.
module sme_ks_arbiter #(
  parameter int D = 3,
  parameter int N = 32
) (
  input  logic           g_clk,
  input  logic           g_resetn,
  // port A
  input  logic           a_req_valid,
  output logic           a_req_ready,
  input  logic           a_sub,
  input  logic [D*N-1:0] a_mxor,
  input  logic [D*N-1:0] a_mand,
  output logic           a_rsp_valid,
  input  logic           a_rsp_ready,
  // port B
  input  logic           b_req_valid,
  output logic           b_req_ready,
  input  logic           b_sub,
  input  logic [D*N-1:0] b_mxor,
  input  logic [D*N-1:0] b_mand,
  output logic           b_rsp_valid,
  input  logic           b_rsp_ready,
  // shared response data
  output logic [D*N-1:0] rsp_rd,
  // adder interface
  output logic           ks_en,
  output logic           ks_sub,
  output logic [D*N-1:0] ks_mxor,
  output logic [D*N-1:0] ks_mand,
  input  logic [D*N-1:0] ks_rd,
  input  logic           ks_rdy,
  output logic           busy
);

  localparam int DN = D * N;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  logic [1:0]    r_state;
  logic          r_gnt;
  logic          r_rr_last;
  logic          r_ks_sub;
  logic [DN-1:0] r_ks_mxor;
  logic [DN-1:0] r_ks_mand;
  logic [DN-1:0] r_rsp_rd;

  logic w_idle;
  logic w_run;
  logic w_resp;
  logic w_pick_b;
  logic w_a_ready;
  logic w_b_ready;
  logic w_grant;
  logic w_rsp_ready;
  logic w_rsp_hs;
  logic w_done;

  assign w_idle = (r_state == S_IDLE);
  assign w_run  = (r_state == S_RUN);
  assign w_resp = (r_state == S_RESP);

  // B wins when it is the only requester, or on a tie when A took the last grant.
  assign w_pick_b = b_req_valid & (~a_req_valid | (r_rr_last == GNT_A));

  // NOTE: ready is qualified by g_resetn so every output reads 0 while reset is held,
  // even if a requester keeps valid asserted through reset.
  assign w_a_ready = g_resetn & w_idle & a_req_valid & ~w_pick_b;
  assign w_b_ready = g_resetn & w_idle & w_pick_b;
  assign w_grant   = w_a_ready | w_b_ready;

  assign w_rsp_ready = (r_gnt == GNT_B) ? b_rsp_ready : a_rsp_ready;
  assign w_rsp_hs    = w_resp & w_rsp_ready;
  assign w_done      = w_run & ks_rdy;

  // Sequencer: IDLE -> RUN on grant, RUN -> RESP on adder done, RESP -> IDLE on response handshake.
  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state   <= S_IDLE;
      r_gnt     <= GNT_A;
      r_rr_last <= GNT_B;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state   <= S_RUN;
            r_gnt     <= w_b_ready;
            r_rr_last <= w_b_ready;
          end
        end
        S_RUN: begin
          if (ks_rdy) r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand shares are loaded only at grant, so shares of two requesters never meet in the adder.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_ks_sub  <= 1'b0;
      r_ks_mxor <= '0;
      r_ks_mand <= '0;
    end else if (w_grant) begin
      r_ks_sub  <= w_b_ready ? b_sub  : a_sub;
      r_ks_mxor <= w_b_ready ? b_mxor : a_mxor;
      r_ks_mand <= w_b_ready ? b_mand : a_mand;
`ifdef SME_KS_ARB_SCRUB_EN
    end else if (w_done) begin
      r_ks_mxor <= '0;
      r_ks_mand <= '0;
`endif
    end
  end

  // Result shares: captured on adder done, held through the response handshake.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_rsp_rd <= '0;
    end else if (w_done) begin
      r_rsp_rd <= ks_rd;
`ifdef SME_KS_ARB_SCRUB_EN
    end else if (w_rsp_hs) begin
      r_rsp_rd <= '0;
`endif
    end
  end

  assign a_req_ready = w_a_ready;
  assign b_req_ready = w_b_ready;
  assign a_rsp_valid = w_resp & (r_gnt == GNT_A);
  assign b_rsp_valid = w_resp & (r_gnt == GNT_B);
  assign rsp_rd      = r_rsp_rd;
  assign ks_en       = w_run;
  assign ks_sub      = r_ks_sub;
  assign ks_mxor     = r_ks_mxor;
  assign ks_mand     = r_ks_mand;
  assign busy        = ~w_idle;

`ifndef SME_KS_ARB_SCRUB_EN
  // Without scrubbing the handshake flag has no consumer; keep it referenced for lint.
  logic w_unused;
  assign w_unused = w_rsp_hs;
`endif

endmodule

// File: tb/tb_sme_ks_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for sme_ks_arbiter: a behavioural 6-cycle masked adder stub and
// a reference model computing results from recombined shares with plain arithmetic.
module tb_sme_ks_arbiter;

  localparam int D  = 3;
  localparam int N  = 32;
  localparam int DN = D * N;

  logic          g_clk;
  logic          g_resetn;
  logic          a_req_valid, a_req_ready, a_sub, a_rsp_valid, a_rsp_ready;
  logic          b_req_valid, b_req_ready, b_sub, b_rsp_valid, b_rsp_ready;
  logic [DN-1:0] a_mxor, a_mand, b_mxor, b_mand;
  logic [DN-1:0] rsp_rd;
  logic          ks_en, ks_sub, ks_rdy, busy;
  logic [DN-1:0] ks_mxor, ks_mand, ks_rd;

  int n_pass  = 0;
  int n_total = 0;
  logic force_rdy = 1'b0;

  sme_ks_arbiter #(.D(D), .N(N)) dut (
    .g_clk       (g_clk),
    .g_resetn    (g_resetn),
    .a_req_valid (a_req_valid),
    .a_req_ready (a_req_ready),
    .a_sub       (a_sub),
    .a_mxor      (a_mxor),
    .a_mand      (a_mand),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_ready (a_rsp_ready),
    .b_req_valid (b_req_valid),
    .b_req_ready (b_req_ready),
    .b_sub       (b_sub),
    .b_mxor      (b_mxor),
    .b_mand      (b_mand),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_ready (b_rsp_ready),
    .rsp_rd      (rsp_rd),
    .ks_en       (ks_en),
    .ks_sub      (ks_sub),
    .ks_mxor     (ks_mxor),
    .ks_mand     (ks_mand),
    .ks_rd       (ks_rd),
    .ks_rdy      (ks_rdy),
    .busy        (busy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] recomb(input logic [DN-1:0] s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < D; i++) r ^= s[i*N +: N];
    return r;
  endfunction

  function automatic logic [DN-1:0] share(input logic [31:0] v);
    logic [DN-1:0] s;
    logic [31:0]   acc;
    acc = v;
    s   = '0;
    for (int i = 1; i < D; i++) begin
      s[i*N +: N] = $urandom;
      acc ^= s[i*N +: N];
    end
    s[N-1:0] = acc;
    return s;
  endfunction

  // Adder stub: ready in the 6th consecutive enabled cycle, then re-armed.
  int unsigned ks_cnt;
  always @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn)  ks_cnt <= 0;
    else if (!ks_en || ks_rdy) ks_cnt <= 0;
    else            ks_cnt <= ks_cnt + 1;
  end
  assign ks_rdy = (ks_en && ks_cnt == 5) || force_rdy;

  // Result shares: operand-A shares with share 0 re-masked so the XOR gives the sum/difference.
  always_comb begin
    logic [31:0] val;
    val   = ks_sub ? recomb(ks_mxor) - recomb(ks_mand) : recomb(ks_mxor) + recomb(ks_mand);
    ks_rd = ks_mxor;
    ks_rd[N-1:0] = ks_mxor[N-1:0] ^ recomb(ks_mxor) ^ val;
  end

  task automatic drive_req(input bit pb, input logic v, input logic sub,
                           input logic [DN-1:0] mx, input logic [DN-1:0] ma);
    if (pb) begin
      b_req_valid = v; b_sub = sub; b_mxor = mx; b_mand = ma;
    end else begin
      a_req_valid = v; a_sub = sub; a_mxor = mx; a_mand = ma;
    end
  endtask

  task automatic clear_inputs();
    a_req_valid = 0; a_sub = 0; a_mxor = '0; a_mand = '0; a_rsp_ready = 0;
    b_req_valid = 0; b_sub = 0; b_mxor = '0; b_mand = '0; b_rsp_ready = 0;
  endtask

  task automatic do_reset();
    g_resetn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);
  endtask

  // One complete operation on port pb, with bp cycles of response backpressure.
  task automatic run_op(input bit pb, input bit sub, input logic [31:0] x,
                        input logic [31:0] y, input int bp, input string tag);
    logic [DN-1:0] sx, sy, rd_exp;
    logic [31:0]   want;
    logic          my_rdy, ot_rdy, my_rv, ot_rv;
    sx   = share(x);
    sy   = share(y);
    want = sub ? x - y : x + y;
    rd_exp = sx;
    rd_exp[N-1:0] = sx[N-1:0] ^ x ^ want;

    @(negedge g_clk);                                   // cycle T
    drive_req(pb, 1'b1, sub, sx, sy);
    #1;
    my_rdy = pb ? b_req_ready : a_req_ready;
    ot_rdy = pb ? a_req_ready : b_req_ready;
    n_total++;
    if (my_rdy !== 1'b1 || ot_rdy !== 1'b0 || ks_en !== 1'b0)
      $display("FAIL %s grant: ready=%b other_ready=%b ks_en=%b want 1/0/0", tag, my_rdy, ot_rdy, ks_en);
    else n_pass++;

    for (int k = 1; k <= 6; k++) begin                  // cycles T+1..T+6
      @(negedge g_clk);
      if (k == 1) drive_req(pb, 1'b0, 1'b0, '0, '0);
      #1;
      n_total++;
      if (ks_en !== 1'b1 || busy !== 1'b1 || ks_sub !== sub || a_req_ready !== 1'b0 ||
          b_req_ready !== 1'b0 || a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0)
        $display("FAIL %s run T+%0d: ks_en=%b busy=%b ks_sub=%b rdy=%b%b rv=%b%b want 1 1 %b 00 00",
                 tag, k, ks_en, busy, ks_sub, a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, sub);
      else n_pass++;
      n_total++;
      if (recomb(ks_mxor) !== x || recomb(ks_mand) !== y)
        $display("FAIL %s operands T+%0d: got %h/%h want %h/%h", tag, k, recomb(ks_mxor), recomb(ks_mand), x, y);
      else n_pass++;
    end

    @(negedge g_clk);                                   // cycle T+7
    if (pb) b_rsp_ready = (bp == 0); else a_rsp_ready = (bp == 0);
    #1;
    my_rv = pb ? b_rsp_valid : a_rsp_valid;
    ot_rv = pb ? a_rsp_valid : b_rsp_valid;
    n_total++;
    if (my_rv !== 1'b1 || ot_rv !== 1'b0 || ks_en !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s resp T+7: rsp_valid=%b other=%b ks_en=%b busy=%b want 1 0 0 1", tag, my_rv, ot_rv, ks_en, busy);
    else n_pass++;
    n_total++;
    if (rsp_rd !== rd_exp)
      $display("FAIL %s result: got %h (sum %h) want %h (sum %h)", tag, rsp_rd, recomb(rsp_rd), rd_exp, want);
    else n_pass++;
`ifdef SME_KS_ARB_SCRUB_EN
    n_total++;
    if (ks_mxor !== '0 || ks_mand !== '0)
      $display("FAIL %s scrub operands: got %h/%h want 0/0", tag, ks_mxor, ks_mand);
    else n_pass++;
`else
    n_total++;
    if (ks_mxor !== sx || ks_mand !== sy)
      $display("FAIL %s operand retain: got %h/%h want %h/%h", tag, ks_mxor, ks_mand, sx, sy);
    else n_pass++;
`endif

    for (int k = 1; k <= bp; k++) begin                 // backpressure, handshake on k == bp
      @(negedge g_clk);
      if (pb) begin
        a_req_valid = (k < bp); a_rsp_ready = (k < bp); b_rsp_ready = (k == bp);
      end else begin
        b_req_valid = (k < bp); b_rsp_ready = (k < bp); a_rsp_ready = (k == bp);
      end
      #1;
      my_rv = pb ? b_rsp_valid : a_rsp_valid;
      n_total++;
      if (rsp_rd !== rd_exp || busy !== 1'b1 || a_req_ready !== 1'b0 || b_req_ready !== 1'b0 || my_rv !== 1'b1)
        $display("FAIL %s hold +%0d: rd=%h busy=%b rdy=%b%b rv=%b want rd=%h 1 00 1",
                 tag, k, rsp_rd, busy, a_req_ready, b_req_ready, my_rv, rd_exp);
      else n_pass++;
    end

    @(negedge g_clk);                                   // cycle after the response handshake
    a_rsp_ready = 0; b_rsp_ready = 0;
    #1;
    n_total++;
    if (busy !== 1'b0 || a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0)
      $display("FAIL %s release: busy=%b rv=%b%b want 0 00", tag, busy, a_rsp_valid, b_rsp_valid);
    else n_pass++;
`ifdef SME_KS_ARB_SCRUB_EN
    n_total++;
    if (rsp_rd !== '0) $display("FAIL %s scrub result: got %h want 0", tag, rsp_rd);
    else n_pass++;
`else
    n_total++;
    if (rsp_rd !== rd_exp) $display("FAIL %s result retain: got %h want %h", tag, rsp_rd, rd_exp);
    else n_pass++;
`endif
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    clear_inputs();
    a_req_valid = 1; b_req_valid = 1; a_rsp_ready = 1; b_rsp_ready = 1;
    @(negedge g_clk);
    #1;
    n_total++;
    if (a_req_ready !== 0 || b_req_ready !== 0 || a_rsp_valid !== 0 || b_rsp_valid !== 0 ||
        ks_en !== 0 || ks_sub !== 0 || busy !== 0)
      $display("FAIL reset ctrl: rdy=%b%b rv=%b%b ks_en=%b ks_sub=%b busy=%b want all 0",
               a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ks_en, ks_sub, busy);
    else n_pass++;
    n_total++;
    if (ks_mxor !== '0 || ks_mand !== '0 || rsp_rd !== '0)
      $display("FAIL reset data: mxor=%h mand=%h rd=%h want 0", ks_mxor, ks_mand, rsp_rd);
    else n_pass++;
    clear_inputs();
    @(negedge g_clk);
    g_resetn = 1'b1;
    // A wins the first tie; dropping both valids before the edge means no grant.
    @(negedge g_clk);
    a_req_valid = 1; b_req_valid = 1;
    #1;
    n_total++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0)
      $display("FAIL first tie: rdy=%b%b want 10", a_req_ready, b_req_ready);
    else n_pass++;
    #1;
    a_req_valid = 0; b_req_valid = 0;
    @(negedge g_clk);
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL withdrawn request: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_single_add();
    run_op(1'b0, 1'b0, 32'd5, 32'd7, 0, "a_add");
  endtask

  task automatic test_b_sub();
    run_op(1'b1, 1'b1, 32'd3, 32'd5, 0, "b_sub");
  endtask

  task automatic test_contention();
    logic [31:0] xa, ya, xb, yb;
    logic [DN-1:0] sxa, sya, sxb, syb;
    bit  exp_last;       // 0 = A, 1 = B
    int  grants, resps, last_cyc;
    bit  port;
    do_reset();
    xa = $urandom; ya = $urandom; xb = $urandom; yb = $urandom;
    sxa = share(xa); sya = share(ya); sxb = share(xb); syb = share(yb);
    exp_last = 1'b1;
    grants = 0; resps = 0; last_cyc = 0;
    drive_req(1'b0, 1'b1, 1'b0, sxa, sya);
    drive_req(1'b1, 1'b1, 1'b1, sxb, syb);
    a_rsp_ready = 1; b_rsp_ready = 1;
    for (int cyc = 0; cyc < 60 && resps < 4; cyc++) begin
      #1;
      if (a_req_ready === 1'b1 || b_req_ready === 1'b1) begin
        port = b_req_ready;
        n_total++;
        if (port !== ~exp_last || (a_req_ready & b_req_ready) !== 1'b0)
          $display("FAIL contention grant %0d: rdy=%b%b want port %0d", grants, a_req_ready, b_req_ready, ~exp_last);
        else n_pass++;
        if (grants > 0) begin
          n_total++;
          if (cyc - last_cyc !== 8)
            $display("FAIL contention interval %0d: got %0d want 8", grants, cyc - last_cyc);
          else n_pass++;
        end
        exp_last = ~exp_last;
        last_cyc = cyc;
        grants++;
      end
      if (a_rsp_valid === 1'b1 || b_rsp_valid === 1'b1) begin
        n_total++;
        if (a_rsp_valid === 1'b1 ? (recomb(rsp_rd) !== xa + ya) : (recomb(rsp_rd) !== xb - yb))
          $display("FAIL contention result %0d: got %h want %h", resps, recomb(rsp_rd),
                   a_rsp_valid === 1'b1 ? xa + ya : xb - yb);
        else n_pass++;
        resps++;
      end
      @(negedge g_clk);
    end
    clear_inputs();
    n_total++;
    if (grants !== 4 || resps !== 4)
      $display("FAIL contention count: grants=%0d resps=%0d want 4/4 within budget", grants, resps);
    else n_pass++;
    repeat (2) @(negedge g_clk);
  endtask

  task automatic test_backpressure();
    run_op(1'b0, 1'b0, $urandom, $urandom, 10, "a_backpressure");
  endtask

  task automatic test_reset_mid_run();
    @(negedge g_clk);
    drive_req(1'b0, 1'b1, 1'b1, share(32'h1234), share(32'h0042));
    #1;
    n_total++;
    if (a_req_ready !== 1'b1) $display("FAIL midrun grant: rdy=%b want 1", a_req_ready);
    else n_pass++;
    @(negedge g_clk);
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge g_clk);                        // now in cycle T+3
    g_resetn = 1'b0;
    b_req_valid = 1'b1;
    #1;
    n_total++;
    if (ks_en !== 0 || busy !== 0 || ks_sub !== 0 || a_req_ready !== 0 || b_req_ready !== 0 ||
        a_rsp_valid !== 0 || b_rsp_valid !== 0 || ks_mxor !== '0 || ks_mand !== '0 || rsp_rd !== '0)
      $display("FAIL midrun reset: ks_en=%b busy=%b sub=%b rdy=%b%b rv=%b%b mxor=%h mand=%h rd=%h want all 0",
               ks_en, busy, ks_sub, a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ks_mxor, ks_mand, rsp_rd);
    else n_pass++;
    @(negedge g_clk);
    b_req_valid = 1'b0;
    g_resetn = 1'b1;
    repeat (2) @(negedge g_clk);
    #1;
    n_total++;
    if (busy !== 1'b0 || a_rsp_valid !== 1'b0) $display("FAIL midrun abandon: busy=%b rv=%b want 0 0", busy, a_rsp_valid);
    else n_pass++;
    run_op(1'b0, 1'b0, $urandom, $urandom, 0, "a_after_reset");
  endtask

  task automatic test_rdy_ignored();
    @(negedge g_clk);
    force_rdy = 1'b1;
    repeat (2) @(negedge g_clk);
    force_rdy = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0 || a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0)
      $display("FAIL idle ks_rdy: busy=%b rv=%b%b want 0 00", busy, a_rsp_valid, b_rsp_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
             int'($urandom_range(0, 3)), "random");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_b_sub();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    test_rdy_ignored();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
